rtlola_eval_scheduler: RTL and testbench

- Sequences evaluation of the generated RTLola monitor datapath.
- Merges event-based input arrivals (`new_input_0`/`input_0`) with an internal periodic deadline into a task queue.
- Pops tasks and drives per-layer enables (`enable_in0`, `enable_out[i]`) so inputs, then each output layer, evaluate in order.
- Exposes the monitor's queue status signals (`q_push`, `q_pop`, `q_push_valid`, `q_pop_valid`).

---
 rtl/rtlola_sched_pkg.sv | 23 ++
 rtl/rtlola_task_fifo.sv | 66 ++++++
 rtl/rtlola_eval_scheduler.sv | 131 +++++++++++++
 tb/tb_rtlola_eval_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtlola_sched_pkg.sv
// rtl/rtlola_sched_pkg.sv - shared task/state types and layer-map helper for the RTLola scheduler
package rtlola_sched_pkg;

    localparam int TASK_DATA_W = 64;
    localparam int LAYER_W     = 2;

    typedef struct packed {
        logic [TASK_DATA_W-1:0] data;
        logic                   has_ev;
        logic                   has_per;
    } task_t;

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_t;

    // The layer map packs LAYER_W bits per output, output 0 in the LSBs.
    function automatic logic [LAYER_W-1:0] out_layer_of(input logic [31:0] layer_map, input int idx);
        return layer_map[idx*LAYER_W +: LAYER_W];
    endfunction

endpackage

// File: rtl/rtlola_task_fifo.sv
// rtl/rtlola_task_fifo.sv - synchronous task FIFO with occupancy count
module rtlola_task_fifo
    import rtlola_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  task_t                  push_data,
    input  logic                   pop,
    output task_t                  pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    task_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/rtlola_eval_scheduler.sv
// rtl/rtlola_eval_scheduler.sv - merges event and periodic tasks and sequences per-layer evaluation
module rtlola_eval_scheduler
    import rtlola_sched_pkg::*;
#(
    parameter int                         DATA_W        = 64,
    parameter int                         NUM_OUTPUTS   = 3,
    parameter int                         NUM_LAYERS    = 3,
    parameter int                         PERIOD_CYCLES = 500,
    parameter int                         QUEUE_DEPTH   = 4,
    parameter logic [2*NUM_OUTPUTS-1:0]   OUT_LAYER     = {2'd1, 2'd2, 2'd1},
    parameter logic [NUM_OUTPUTS-1:0]     EVENT_MASK    = 3'b011,
    parameter logic [NUM_OUTPUTS-1:0]     PERIODIC_MASK = 3'b100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   new_input_0,
    input  logic [DATA_W-1:0]      input_0,
    output logic [DATA_W-1:0]      task_data,
    output logic                   q_push,
    output logic                   q_push_valid,
    output logic                   q_pop,
    output logic                   q_pop_valid,
    output logic                   enable_in0,
    output logic [NUM_OUTPUTS-1:0] enable_out,
    output logic                   busy,
    output logic                   overflow
);

    localparam int TIMER_W = $clog2(PERIOD_CYCLES);

    logic [TIMER_W-1:0]         timer_q, timer_d;
    state_t                     state_q, state_d;
    logic [LAYER_W-1:0]         layer_q, layer_d;
    task_t                      task_q, task_d;
    logic                       overflow_q, overflow_d;

    logic                       run;
    logic                       tick;
    logic                       last_layer;
    task_t                      push_entry;
    task_t                      fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(QUEUE_DEPTH):0] fifo_count;

    // Reset also gates the combinational strobes so every output is 0 while rst is low.
    assign run          = en & rst;
    assign tick         = (timer_q == TIMER_W'(PERIOD_CYCLES - 1));
    assign last_layer   = (state_q == EVAL) && (layer_q == LAYER_W'(NUM_LAYERS - 1));
    assign q_push       = run & (new_input_0 | tick);
    assign q_pop        = run & ((state_q == IDLE) | last_layer);
    assign q_pop_valid  = q_pop & ~fifo_empty;
    assign q_push_valid = q_push & (~fifo_full | q_pop_valid);

    always_comb begin
        push_entry         = '0;
        push_entry.has_ev  = new_input_0;
        push_entry.has_per = tick;
        if (new_input_0) begin
            push_entry.data = TASK_DATA_W'(input_0);
        end
    end

    rtlola_task_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_task_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (q_push_valid),
        .push_data(push_entry),
        .pop      (q_pop_valid),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        timer_d    = timer_q;
        state_d    = state_q;
        layer_d    = layer_q;
        task_d     = task_q;
        overflow_d = overflow_q | (q_push & ~q_push_valid);
        if (run) begin
            timer_d = tick ? '0 : timer_q + TIMER_W'(1);
            // A pop on the last layer chains straight into layer 0 of the next task.
            if (q_pop_valid) begin
                state_d = EVAL;
                layer_d = '0;
                task_d  = fifo_head;
            end else if (last_layer) begin
                state_d = IDLE;
                layer_d = '0;
                task_d  = '0;
            end else if (state_q == EVAL) begin
                layer_d = layer_q + LAYER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q    <= '0;
            state_q    <= IDLE;
            layer_q    <= '0;
            task_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            state_q    <= state_d;
            layer_q    <= layer_d;
            task_q     <= task_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        enable_in0 = run && (state_q == EVAL) && (layer_q == '0) && task_q.has_ev;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            enable_out[i] = run && (state_q == EVAL)
                && (layer_q == out_layer_of(32'(OUT_LAYER), i))
                && ((task_q.has_ev && EVENT_MASK[i]) || (task_q.has_per && PERIODIC_MASK[i]));
        end
    end

    assign task_data = (state_q == EVAL) ? DATA_W'(task_q.data) : '0;
    assign busy      = (state_q == EVAL) | (fifo_count != '0);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_rtlola_eval_scheduler.sv
// tb/tb_rtlola_eval_scheduler.sv - scoreboard bench for rtlola_eval_scheduler
module tb_rtlola_eval_scheduler;

    localparam int PERIOD = 8;
    localparam int NL     = 3;
    localparam logic [5:0] LAYER_OF = {2'd1, 2'd2, 2'd1};
    localparam logic [2:0] EV_M     = 3'b011;
    localparam logic [2:0] PER_M    = 3'b100;

    typedef struct packed {
        logic [63:0] data;
        logic        ev;
        logic        per;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        new_input_0 = 1'b0;
    logic [63:0] input_0 = '0;
    logic [63:0] task_data;
    logic        q_push, q_push_valid, q_pop, q_pop_valid, enable_in0, busy, overflow;
    logic [2:0]  enable_out;

    int   chk_cnt = 0;
    int   err_cnt = 0;
    int   tcnt = 0;
    int   mon_layer = -1;
    sb_t  sb[$];
    sb_t  cur;

    logic        obs_pv, obs_in0, obs_busy, obs_ovf;
    logic [2:0]  obs_out;
    logic [63:0] obs_data;

    rtlola_eval_scheduler #(
        .PERIOD_CYCLES(PERIOD)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .new_input_0 (new_input_0),
        .input_0     (input_0),
        .task_data   (task_data),
        .q_push      (q_push),
        .q_push_valid(q_push_valid),
        .q_pop       (q_pop),
        .q_pop_valid (q_pop_valid),
        .enable_in0  (enable_in0),
        .enable_out  (enable_out),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_in0(input sb_t t, input int l);
        return (l == 0) && t.ev;
    endfunction

    function automatic logic [2:0] exp_out(input sb_t t, input int l);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i] = (int'(LAYER_OF[2*i +: 2]) == l) && ((t.ev && EV_M[i]) || (t.per && PER_M[i]));
        end
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, task_data, 64'd0);
        check({tag, "_ctrl"}, 64'({q_push, q_push_valid, q_pop, q_pop_valid, enable_in0,
                                   enable_out, busy, overflow}), 64'd0);
    endtask

    // Holds reset for one cycle, checks the reset state, releases just after a rising edge.
    task automatic do_reset();
        rst = 1'b0;
        en = 1'b1;
        new_input_0 = 1'b0;
        input_0 = '0;
        sb.delete();
        mon_layer = -1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tcnt = 0;
    endtask

    // One cycle: drive inputs, check push behaviour against the timer model, record outputs.
    task automatic cyc_drive(input logic s, input logic [63:0] v, input logic e, input logic acc);
        logic tick_e;
        logic push_e;
        sb_t  ent;
        new_input_0 = s;
        input_0 = v;
        en = e;
        tick_e = e && (tcnt == PERIOD - 1);
        push_e = e && (s || tick_e);
        @(negedge clk);
        check("q_push", 64'(q_push), 64'(push_e));
        if (push_e) begin
            check("q_push_valid", 64'(q_push_valid), 64'(acc));
            if (acc) begin
                ent.data = s ? v : 64'd0;
                ent.ev = s;
                ent.per = tick_e;
                sb.push_back(ent);
            end
        end
        if (!e) begin
            check("q_pop_frozen", 64'(q_pop), 64'd0);
        end
        obs_pv = q_pop_valid;
        obs_in0 = enable_in0;
        obs_out = enable_out;
        obs_busy = busy;
        obs_ovf = overflow;
        obs_data = task_data;
        @(posedge clk);
        #1;
        if (e) begin
            tcnt = (tcnt == PERIOD - 1) ? 0 : tcnt + 1;
        end
        new_input_0 = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mon_layer >= 0 && en) begin
                    check("sb_in0", 64'(enable_in0), 64'(exp_in0(cur, mon_layer)));
                    check("sb_out", 64'(enable_out), 64'(exp_out(cur, mon_layer)));
                    check("sb_data", task_data, cur.data);
                    mon_layer = (mon_layer == NL - 1) ? -1 : mon_layer + 1;
                end else begin
                    check("quiet_en", 64'({enable_in0, enable_out}), 64'd0);
                    if (mon_layer < 0) begin
                        check("idle_data", task_data, 64'd0);
                    end
                end
                if (q_pop_valid) begin
                    check("pop_timing", 64'(mon_layer < 0), 64'd1);
                    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        cur = sb.pop_front();
                        mon_layer = 0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic s;
        // Periodic-only operation
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cyc_drive(1'b0, 64'd0, 1'b1, 1'b1);
            if (c == 8 || c == 16) check("per_pop", 64'(obs_pv), 64'd1);
            if (c == 9 || c == 11) check("per_gap", 64'({obs_in0, obs_out}), 64'd0);
            if (c == 10 || c == 18) check("per_out", 64'(obs_out), 64'b100);
        end

        // Single event latency
        do_reset();
        for (int c = 0; c < 12; c++) begin
            s = (c == 2);
            cyc_drive(s, s ? 64'd5 : 64'd0, 1'b1, 1'b1);
            if (c == 3) check("ev_pop", 64'(obs_pv), 64'd1);
            if (c == 4) check("ev_in0", 64'(obs_in0), 64'd1);
            if (c == 4) check("ev_data", obs_data, 64'd5);
            if (c == 5) check("ev_l1", 64'(obs_out), 64'b001);
            if (c == 6) check("ev_l2", 64'(obs_out), 64'b010);
            if (c == 7) check("ev_busy", 64'(obs_busy), 64'd0);
        end

        // Event coinciding with a tick
        do_reset();
        for (int c = 0; c < 13; c++) begin
            s = (c == 7);
            cyc_drive(s, s ? -64'sd3 : 64'd0, 1'b1, 1'b1);
            if (c == 9) check("comb_in0", 64'(obs_in0), 64'd1);
            if (c == 9) check("comb_data", obs_data, -64'sd3);
            if (c == 10) check("comb_l1", 64'(obs_out), 64'b101);
            if (c == 11) check("comb_l2", 64'(obs_out), 64'b010);
        end

        // Five back-to-back events
        do_reset();
        for (int c = 0; c < 29; c++) begin
            s = (c < 5);
            cyc_drive(s, s ? 64'(c + 1) : 64'd0, 1'b1, 1'b1);
            if (c >= 2 && c <= 14 && (c - 2) % 3 == 0) begin
                check("b2b_in0", 64'(obs_in0), 64'd1);
                check("b2b_data", obs_data, 64'((c - 2) / 3 + 1));
            end
            if (c == 28) begin
                check("b2b_ovf", 64'(obs_ovf), 64'd0);
                check("b2b_busy", 64'(obs_busy), 64'd0);
                check("b2b_drain", 64'(sb.size()), 64'd0);
            end
        end

        // Seven back-to-back events: the seventh hits a full queue with no pop
        do_reset();
        for (int c = 0; c < 30; c++) begin
            s = (c < 7);
            cyc_drive(s, s ? 64'(c + 1) : 64'd0, 1'b1, (c != 6));
            if (c == 5) check("ovf_before", 64'(obs_ovf), 64'd0);
            if (c == 6) check("ovf_nopop", 64'(obs_pv), 64'd0);
            if (c == 7) check("ovf_set", 64'(obs_ovf), 64'd1);
            if (c == 29) begin
                check("ovf_sticky", 64'(obs_ovf), 64'd1);
                check("ovf_busy", 64'(obs_busy), 64'd0);
                check("ovf_drain", 64'(sb.size()), 64'd0);
            end
        end

        // Reset asserted during layer 1
        do_reset();
        for (int c = 0; c < 3; c++) begin
            s = (c == 0);
            cyc_drive(s, s ? 64'h11 : 64'd0, 1'b1, 1'b1);
        end
        rst = 1'b0;
        en = 1'b1;
        new_input_0 = 1'b1;
        input_0 = 64'h99;
        @(negedge clk);
        check_all_zero("mid_rst");
        do_reset();
        for (int c = 0; c < 12; c++) begin
            cyc_drive(1'b0, 64'd0, 1'b1, 1'b1);
            if (c < 7) check("rst_empty", 64'({obs_busy, obs_pv}), 64'd0);
            if (c == 8) check("rst_tick_pop", 64'(obs_pv), 64'd1);
            if (c == 10) check("rst_tick_out", 64'(obs_out), 64'b100);
        end

        // Enable dropped for three cycles during layer 1
        do_reset();
        for (int c = 0; c < 20; c++) begin
            s = (c == 0 || c == 4);
            cyc_drive(s, (c == 0) ? 64'h22 : ((c == 4) ? 64'h33 : 64'd0), !(c >= 3 && c <= 5), 1'b1);
            if (c >= 3 && c <= 5) check("en_freeze", 64'({obs_in0, obs_out}), 64'd0);
            if (c == 6) check("en_resume_l1", 64'(obs_out), 64'b001);
            if (c == 7) check("en_resume_l2", 64'(obs_out), 64'b010);
            if (c == 13) check("en_tick_out", 64'(obs_out), 64'b100);
        end
        check("en_drain", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
